// File: rtl/gcd_operand_queue.sv
// gcd_operand_queue
//
// Upstream feeder for the GCD datapath/control pair. Operand pairs (a, b)
// arrive on a valid/ready interface and are buffered in a small show-ahead
// FIFO. The head pair is presented on op_a/op_b with avail, and is popped
// when the GCD control unit pulses take. Pairs where both operands are zero
// have no GCD: they are accepted, never stored, and counted in drop_cnt.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   in_valid      source presents a pair on in_a/in_b
//   in_ready      queue can accept a pair this cycle (state-only, no bypass)
//   in_a, in_b    incoming operands
//   avail         head pair valid (drives GCD control avail)
//   take          one-cycle pop request from the consumer
//   op_a, op_b    head operands, zero when the queue is empty
//   count         number of stored pairs, 0..DEPTH
//   drop_cnt      saturating count of discarded zero/zero pairs
//   drop_pulse    registered one-cycle flag after a zero/zero pair is accepted
module gcd_operand_queue #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  output logic                       avail,
  input  logic                       take,
  output logic [WIDTH-1:0]           op_a,
  output logic [WIDTH-1:0]           op_b,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           drop_cnt,
  output logic                       drop_pulse
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_W'(1);
  endfunction

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count_q;
  logic [CNT_W-1:0] drop_cnt_q;
  logic             drop_pulse_q;

  logic accept;
  logic zero_pair;
  logic push;
  logic pop;

  // Readiness depends on stored state only; a same-cycle take does not
  // free a slot for the incoming pair.
  assign in_ready  = (count_q != FULL_CNT);
  assign avail     = (count_q != '0);
  assign accept    = in_valid & in_ready;
  assign zero_pair = accept & (in_a == '0) & (in_b == '0);
  assign push      = accept & ~zero_pair;
  assign pop       = take & avail;

  assign op_a       = avail ? mem_a[rd_ptr] : '0;
  assign op_b       = avail ? mem_b[rd_ptr] : '0;
  assign count      = count_q;
  assign drop_cnt   = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;

  // Storage holds data only and is not reset; pointers and count gate it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (zero_pair) begin
        drop_cnt_q <= sat_inc(drop_cnt_q);
      end
      drop_pulse_q <= zero_pair;
    end
  end

endmodule

// File: tb/tb_gcd_operand_queue.sv
// Self-checking bench for gcd_operand_queue: directed steps from the test
// plan followed by random traffic, all checked against a queue-based model.
module tb_gcd_operand_queue;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             avail;
  logic             take;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [$clog2(DEPTH):0] count;
  logic [CNT_W-1:0] drop_cnt;
  logic             drop_pulse;

  gcd_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .avail(avail), .take(take), .op_a(op_a), .op_b(op_b),
    .count(count), .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  pair_t m_q[$];
  int    m_drop;
  bit    m_pulse;
  int    total = 0;
  int    bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("avail",      32'(avail),      32'(m_q.size() != 0));
    chk("op_a",       32'(op_a),       m_q.size() != 0 ? 32'(m_q[0].a) : 32'd0);
    chk("op_b",       32'(op_b),       m_q.size() != 0 ? 32'(m_q[0].b) : 32'd0);
    chk("count",      32'(count),      32'(m_q.size()));
    chk("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
    chk("drop_cnt",   32'(drop_cnt),   32'(m_drop));
    chk("drop_pulse", 32'(drop_pulse), 32'(m_pulse));
  endtask

  // One clock cycle: apply inputs, advance the model, check after the edge.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic t);
    bit acc;
    bit zero;
    rst = r; in_valid = v; in_a = a; in_b = b; take = t;
    #1;
    chk("in_ready_pre", 32'(in_ready), 32'(m_q.size() != DEPTH));
    if (r) begin
      m_q.delete();
      m_drop  = 0;
      m_pulse = 0;
    end else begin
      acc  = v && (m_q.size() != DEPTH);
      zero = acc && (a == 0) && (b == 0);
      if (t && m_q.size() != 0) void'(m_q.pop_front());
      if (acc && !zero) m_q.push_back('{a: a, b: b});
      if (zero && m_drop < DROP_MAX) m_drop++;
      m_pulse = zero;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    step(1'b0, 1'b1, a, b, 1'b0);
  endtask

  task automatic pop_one();
    step(1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; take = 1'b0;
    m_drop = 0; m_pulse = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    idle();
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_avail", 32'(avail), 32'd0);

    // Single pair then take.
    push(16'd48, 16'd18);
    chk("single_a", 32'(op_a), 32'd48);
    chk("single_b", 32'(op_b), 32'd18);
    pop_one();
    chk("single_empty", 32'(avail), 32'd0);

    // Fill to full; a fifth pair with take in the same cycle is refused.
    push(16'd1, 16'd2); push(16'd3, 16'd4); push(16'd5, 16'd6); push(16'd7, 16'd8);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1'b0, 1'b1, 16'd9, 16'd10, 1'b1);
    chk("nobypass_count", 32'(count), 32'd3);
    chk("nobypass_head", 32'(op_a), 32'd3);
    pop_one(); pop_one(); pop_one();

    // Fill/drain rounds to wrap the pointers.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 3; k++) push(16'(100 + 10 * r + k), 16'(200 + k));
      for (int k = 0; k < 3; k++) pop_one();
    end
    chk("wrap_count", 32'(count), 32'd0);

    // Push and pop together at count=1.
    push(16'd21, 16'd6);
    step(1'b0, 1'b1, 16'd9, 16'd0, 1'b1);
    chk("swap_head_a", 32'(op_a), 32'd9);
    chk("swap_avail", 32'(avail), 32'd1);
    pop_one();

    // Zero/zero pairs are dropped; a single zero operand is kept.
    push(16'd0, 16'd0);
    idle();
    push(16'd0, 16'd0);
    push(16'd0, 16'd5);
    chk("drop_two", 32'(drop_cnt), 32'd2);
    chk("one_zero_b", 32'(op_b), 32'd5);
    pop_one();

    // Saturation of the drop counter.
    for (int k = 0; k < 256; k++) push(16'd0, 16'd0);
    chk("drop_sat", 32'(drop_cnt), 32'd255);

    // Reset with pairs queued.
    push(16'd1, 16'd1); push(16'd2, 16'd2); push(16'd3, 16'd3);
    step(1'b1, 1'b0, '0, '0, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_avail", 32'(avail), 32'd0);

    // Random traffic, including zero operands and idle takes.
    for (int k = 0; k < 400; k++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
      step(1'b0, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gcd_operand_queue.md
Name: gcd_operand_queue

Overview:
Upstream feeder for the GCD datapath/control pair. It accepts operand pairs (a, b) from a valid/ready source and buffers them in a small show-ahead FIFO. It presents the head pair with an avail flag, which drives the GCD control unit's avail input, and pops the head on take. Pairs with both operands zero have no GCD; they are accepted, discarded and counted.

Parameters:
WIDTH, 16, operand width in bits
DEPTH, 4, FIFO entries; power of 2, >= 2
CNT_W, 8, width of the dropped-pair counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  source presents a pair
in_ready  out  1  queue can accept a pair this cycle
in_a  in  WIDTH  operand a from source
in_b  in  WIDTH  operand b from source
avail  out  1  head pair valid; to GCD control unit avail
take  in  1  consumer latched head pair; pop (pulse in the cycle the GCD loads operands)
op_a  out  WIDTH  head operand a
op_b  out  WIDTH  head operand b
count  out  $clog2(DEPTH)+1  stored entries, 0..DEPTH
drop_cnt  out  CNT_W  number of discarded zero/zero pairs, saturating
drop_pulse  out  1  one-cycle pulse, registered, in the cycle after a zero/zero pair is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - Read/write pointers, count, drop_cnt and drop_pulse all go to 0.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued pairs; avail is 0 in the next cycle.
- in_ready = (count != DEPTH). Combinational from state only, never from in_valid or take. There is no full-bypass: when count == DEPTH, in_ready = 0 even if take=1 in the same cycle.
- accept = in_valid & in_ready.
- zero_pair = accept & (in_a == 0) & (in_b == 0).
- push = accept & ~zero_pair.
- zero_pair:
  - Nothing is stored; count is unchanged by it.
  - drop_cnt increments, saturating at 2^CNT_W-1.
  - drop_pulse = 1 in the next cycle.
- Pairs with exactly one zero operand are stored normally; the GCD handles them.
- push writes {in_a, in_b} at the write pointer, and the write pointer increments modulo DEPTH.
- avail = (count != 0). op_a/op_b = entry at the read pointer, combinational show-ahead. op_a = op_b = 0 when count == 0.
- pop = take & avail. The read pointer increments modulo DEPTH. take while avail=0 is ignored: no pointer or count change, and no error.
- Count update per cycle:
  - push & ~pop: +1
  - pop & ~push: -1
  - both or neither: unchanged
- Simultaneous push & pop with count=1: the new pair becomes head next cycle and avail stays 1.
- Latency: a pair accepted at edge N is visible (avail=1, op_a/op_b valid) after edge N. Head change after pop is visible after the same edge.
- Ordering: strict FIFO; pointer wrap is transparent.
- Operand values are passed unmodified; no swap or normalisation.
- Consumer contract: take is asserted for exactly one cycle per pair consumed, while avail=1.

Test Plan:
- Reset then idle -> in_ready=1, avail=0, count=0, op_a=op_b=0, drop_cnt=0.
- Push (48,18), then take one cycle later -> avail=1, op_a=48, op_b=18, count=1; after take, avail=0, count=0.
- Push 4 pairs (1,2),(3,4),(5,6),(7,8) with no take -> count=4, in_ready=0. A 5th in_valid with take=1 the same cycle -> 5th not accepted, count=3, head=(3,4). Drain 3 more pairs in order.
- Repeat 3 fill/drain rounds of 3 pairs to wrap the pointers -> output order matches input order; count returns to 0.
- With count=1, push (9,0) and take in the same cycle -> count stays 1, head becomes (9,0), avail held at 1.
- Push (0,0) twice, then (0,5) -> drop_cnt=2, drop_pulse high for 1 cycle after each (0,0) push, only (0,5) queued.
- Push 256 (0,0) pairs with CNT_W=8 -> drop_cnt saturates at 255.
- Assert rst with count=3 -> next cycle count=0, avail=0, in_ready=1.
